quaternion_normalisation: RTL and testbench

- Normalises a signed fixed-point quaternion {w,x,y,z} to unit magnitude: q / sqrt(w²+x²+y²+z²).
- Sits in the Madgwick attitude filter datapath; normalises both the gradient-step q̂̇ and the integrated attitude q.
- Start/done handshake; contains its own bit-serial inverse-square-root unit with a valid/ready handshake.
- Intermediate signals are exported as debug ports.

---
 rtl/quaternion_normalisation.sv | 244 ++++++++++++++++++++++++
 tb/tb_quaternion_normalisation.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/quaternion_normalisation.sv
// rtl/quaternion_normalisation.sv - fixed-point quaternion normaliser with bit-serial inverse square root

module inv_sqrt_serial #(
    parameter int WIDTH = 32,
    parameter int FRACT = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [WIDTH-1:0] data_out
);
    localparam int PW = 3 * WIDTH;
    // 1.0 expressed with the 3*FRACT fraction bits of y*y*m
    localparam logic [PW-1:0] ONE = PW'(1) << (3 * FRACT);

    logic               busy;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   y_q;
    logic [WIDTH-1:0]   mask_q;
    logic [WIDTH-1:0]   trial;
    logic [2*WIDTH-1:0] t_sq;
    logic [PW-1:0]      prod;
    logic               fits;

    // Trial bit acceptance test: keep the bit while (y|bit)^2 * m stays at or below 1.0
    always_comb begin
        trial = y_q | mask_q;
        t_sq  = (2*WIDTH)'(trial) * (2*WIDTH)'(trial);
        prod  = PW'(t_sq) * PW'(m_q);
        fits  = (prod <= ONE);
    end

    // Operand capture, one result bit per cycle MSB first, result held until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            valid_out <= 1'b0;
            m_q       <= '0;
            y_q       <= '0;
            mask_q    <= '0;
        end else begin
            if (valid_out && ready_out)
                valid_out <= 1'b0;
            if (valid_in && ready_in) begin
                m_q    <= data_in;
                y_q    <= '0;
                mask_q <= {1'b1, {(WIDTH-1){1'b0}}};
                busy   <= 1'b1;
            end else if (busy) begin
                if (fits)
                    y_q <= trial;
                mask_q <= mask_q >> 1;
                if (mask_q[0]) begin
                    busy      <= 1'b0;
                    valid_out <= 1'b1;
                end
            end
        end
    end

    assign ready_in = !busy && !valid_out;
    assign data_out = y_q;
endmodule

module quaternion_normalisation #(
    parameter int INPUT_INT_WIDTH     = 2,
    parameter int INPUT_FRACT_WIDTH   = 14,
    parameter int MAG_SQR_INT_WIDTH   = 6,
    parameter int MAG_SQR_FRACT_WIDTH = 26
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     done,
    input  logic [4*(INPUT_INT_WIDTH+INPUT_FRACT_WIDTH)-1:0] data_in,
    output logic [4*(INPUT_INT_WIDTH+INPUT_FRACT_WIDTH)-1:0] data_out,
    output logic [INPUT_INT_WIDTH+INPUT_FRACT_WIDTH+MAG_SQR_INT_WIDTH+MAG_SQR_FRACT_WIDTH-1:0] q_w_norm_temp,
    output logic [INPUT_INT_WIDTH+INPUT_FRACT_WIDTH+MAG_SQR_INT_WIDTH+MAG_SQR_FRACT_WIDTH-1:0] q_x_norm_temp,
    output logic [INPUT_INT_WIDTH+INPUT_FRACT_WIDTH+MAG_SQR_INT_WIDTH+MAG_SQR_FRACT_WIDTH-1:0] q_y_norm_temp,
    output logic [INPUT_INT_WIDTH+INPUT_FRACT_WIDTH+MAG_SQR_INT_WIDTH+MAG_SQR_FRACT_WIDTH-1:0] q_z_norm_temp,
    output logic [INPUT_INT_WIDTH+INPUT_FRACT_WIDTH+MAG_SQR_INT_WIDTH+MAG_SQR_FRACT_WIDTH:0]   q_w_norm_rounded,
    output logic [INPUT_INT_WIDTH+INPUT_FRACT_WIDTH+MAG_SQR_INT_WIDTH+MAG_SQR_FRACT_WIDTH:0]   q_x_norm_rounded,
    output logic [INPUT_INT_WIDTH+INPUT_FRACT_WIDTH+MAG_SQR_INT_WIDTH+MAG_SQR_FRACT_WIDTH:0]   q_y_norm_rounded,
    output logic [INPUT_INT_WIDTH+INPUT_FRACT_WIDTH+MAG_SQR_INT_WIDTH+MAG_SQR_FRACT_WIDTH:0]   q_z_norm_rounded,
    output logic [INPUT_INT_WIDTH+INPUT_FRACT_WIDTH+MAG_SQR_INT_WIDTH+MAG_SQR_FRACT_WIDTH-1:0] q_norm_round_const,
    output logic [INPUT_INT_WIDTH+INPUT_FRACT_WIDTH-1:0] q_w_norm,
    output logic [INPUT_INT_WIDTH+INPUT_FRACT_WIDTH-1:0] q_x_norm,
    output logic [INPUT_INT_WIDTH+INPUT_FRACT_WIDTH-1:0] q_y_norm,
    output logic [INPUT_INT_WIDTH+INPUT_FRACT_WIDTH-1:0] q_z_norm,
    output logic [2*(INPUT_INT_WIDTH+INPUT_FRACT_WIDTH)+2:0] q_mag_sqr,
    output logic [2*(INPUT_INT_WIDTH+INPUT_FRACT_WIDTH)+2:0] q_mag_sqr_rounded,
    output logic [2*(INPUT_INT_WIDTH+INPUT_FRACT_WIDTH)+2:0] q_mag_sqr_round_const,
    output logic [MAG_SQR_INT_WIDTH+MAG_SQR_FRACT_WIDTH-1:0] data_in_invSqrt,
    output logic [MAG_SQR_INT_WIDTH+MAG_SQR_FRACT_WIDTH-1:0] data_out_invSqrt,
    output logic                     valid_in_invSqrt,
    output logic                     ready_in_invSqrt,
    output logic                     valid_out_invSqrt,
    output logic                     ready_out_invSqrt,
    output logic [2:0]               debug_state
);
    localparam int W   = INPUT_INT_WIDTH + INPUT_FRACT_WIDTH;
    localparam int M   = MAG_SQR_INT_WIDTH + MAG_SQR_FRACT_WIDTH;
    localparam int MF  = MAG_SQR_FRACT_WIDTH;
    localparam int SW  = 2 * W + 3;
    localparam int RSH = (2 * INPUT_FRACT_WIDTH > MF) ? (2 * INPUT_FRACT_WIDTH - MF) : 0;
    localparam int LSH = (2 * INPUT_FRACT_WIDTH > MF) ? 0 : (MF - 2 * INPUT_FRACT_WIDTH);
    localparam int RC_SH = (RSH > 0) ? (RSH - 1) : 0;
    localparam int XW  = SW + LSH;
    localparam int SHW = W + M + 1 - MF;
    localparam logic [SW-1:0]         MAG_RC    = (RSH > 0) ? (SW'(1) << RC_SH) : '0;
    localparam logic [XW-1:0]         MAG_LIMIT = XW'({M{1'b1}});
    localparam logic [W+M-1:0]        NORM_RC   = (W+M)'(1) << (MF - 1);
    localparam logic [W-1:0]          POS_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]          NEG_MIN   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MAG      = 3'd1,
        S_INV_REQ  = 3'd2,
        S_INV_WAIT = 3'd3,
        S_NORM     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [3:0][W-1:0]    comp_q;
    logic [M-1:0]         inv_q;
    logic [2*W-1:0]       sq [4];
    logic [XW-1:0]        mag_scaled;
    logic [M-1:0]         mag_sat;
    logic signed [W+M-1:0] temp [4];
    logic signed [W+M:0]   rnd [4];
    logic signed [SHW-1:0] shf [4];
    logic [W-1:0]         nrm [4];

    for (genvar i = 0; i < 4; i++) begin : gen_comp
        logic signed [2*W-1:0] c_ext;
        logic signed [W+M-1:0] c_wide;
        logic signed [W+M-1:0] inv_wide;
        assign c_ext    = (2*W)'($signed(comp_q[i]));
        assign sq[i]    = c_ext * c_ext;
        assign c_wide   = (W+M)'($signed(comp_q[i]));
        assign inv_wide = (W+M)'({1'b0, inv_q});
        assign temp[i]  = c_wide * inv_wide;
        assign rnd[i]   = (W+M+1)'(temp[i]) + (W+M+1)'(NORM_RC);
        assign shf[i]   = SHW'(rnd[i] >>> MF);
    end

    // Magnitude squared, rounding to the invSqrt fraction width and saturation to M bits
    always_comb begin
        q_mag_sqr         = SW'(sq[0]) + SW'(sq[1]) + SW'(sq[2]) + SW'(sq[3]);
        q_mag_sqr_rounded = q_mag_sqr + MAG_RC;
        mag_scaled        = (XW'(q_mag_sqr_rounded) << LSH) >> RSH;
        mag_sat           = (mag_scaled > MAG_LIMIT) ? {M{1'b1}} : M'(mag_scaled);
    end

    // Round-to-nearest scaled components, clamped to the signed W-bit range
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nrm[i] = shf[i][W-1:0];
            if (!((~|shf[i][SHW-1:W-1]) || (&shf[i][SHW-1:W-1])))
                nrm[i] = shf[i][SHW-1] ? NEG_MIN : POS_MAX;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state sequencing through magnitude, invSqrt handshake and normalisation
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_MAG;
            S_MAG:      state_nxt = S_INV_REQ;
            S_INV_REQ:  if (ready_in_invSqrt) state_nxt = S_INV_WAIT;
            S_INV_WAIT: if (valid_out_invSqrt) state_nxt = S_NORM;
            S_NORM:     state_nxt = S_DONE;
            S_DONE:     if (!start) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers: input latch, invSqrt operand, captured result and output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_q          <= '0;
            data_in_invSqrt <= '0;
            inv_q           <= '0;
            data_out        <= '0;
        end else begin
            if (state == S_IDLE && start)
                comp_q <= data_in;
            if (state == S_MAG)
                data_in_invSqrt <= mag_sat;
            if (state == S_INV_WAIT && valid_out_invSqrt)
                inv_q <= data_out_invSqrt;
            if (state == S_NORM)
                data_out <= {nrm[3], nrm[2], nrm[1], nrm[0]};
        end
    end

    inv_sqrt_serial #(
        .WIDTH (M),
        .FRACT (MF)
    ) u_inv_sqrt (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in_invSqrt),
        .ready_in  (ready_in_invSqrt),
        .data_in   (data_in_invSqrt),
        .valid_out (valid_out_invSqrt),
        .ready_out (ready_out_invSqrt),
        .data_out  (data_out_invSqrt)
    );

    assign valid_in_invSqrt      = (state == S_INV_REQ);
    assign ready_out_invSqrt     = (state == S_INV_WAIT);
    assign done                  = (state == S_DONE);
    assign debug_state           = state;
    assign q_mag_sqr_round_const = MAG_RC;
    assign q_norm_round_const    = NORM_RC;
    assign q_w_norm_temp         = temp[3];
    assign q_x_norm_temp         = temp[2];
    assign q_y_norm_temp         = temp[1];
    assign q_z_norm_temp         = temp[0];
    assign q_w_norm_rounded      = rnd[3];
    assign q_x_norm_rounded      = rnd[2];
    assign q_y_norm_rounded      = rnd[1];
    assign q_z_norm_rounded      = rnd[0];
    assign q_w_norm              = nrm[3];
    assign q_x_norm              = nrm[2];
    assign q_y_norm              = nrm[1];
    assign q_z_norm              = nrm[0];
endmodule

// File: tb/tb_quaternion_normalisation.sv
// tb/tb_quaternion_normalisation.sv - self-checking bench for quaternion_normalisation

module tb_quaternion_normalisation;
    localparam int W  = 16;
    localparam int M  = 32;
    localparam int SW = 2 * W + 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [4*W-1:0]  data_in = '0;
    logic            done;
    logic [4*W-1:0]  data_out;
    logic [W+M-1:0]  q_w_norm_temp, q_x_norm_temp, q_y_norm_temp, q_z_norm_temp;
    logic [W+M:0]    q_w_norm_rounded, q_x_norm_rounded, q_y_norm_rounded, q_z_norm_rounded;
    logic [W+M-1:0]  q_norm_round_const;
    logic [W-1:0]    q_w_norm, q_x_norm, q_y_norm, q_z_norm;
    logic [SW-1:0]   q_mag_sqr, q_mag_sqr_rounded, q_mag_sqr_round_const;
    logic [M-1:0]    data_in_invSqrt, data_out_invSqrt;
    logic            valid_in_invSqrt, ready_in_invSqrt, valid_out_invSqrt, ready_out_invSqrt;
    logic [2:0]      debug_state;

    quaternion_normalisation dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .done                  (done),
        .data_in               (data_in),
        .data_out              (data_out),
        .q_w_norm_temp         (q_w_norm_temp),
        .q_x_norm_temp         (q_x_norm_temp),
        .q_y_norm_temp         (q_y_norm_temp),
        .q_z_norm_temp         (q_z_norm_temp),
        .q_w_norm_rounded      (q_w_norm_rounded),
        .q_x_norm_rounded      (q_x_norm_rounded),
        .q_y_norm_rounded      (q_y_norm_rounded),
        .q_z_norm_rounded      (q_z_norm_rounded),
        .q_norm_round_const    (q_norm_round_const),
        .q_w_norm              (q_w_norm),
        .q_x_norm              (q_x_norm),
        .q_y_norm              (q_y_norm),
        .q_z_norm              (q_z_norm),
        .q_mag_sqr             (q_mag_sqr),
        .q_mag_sqr_rounded     (q_mag_sqr_rounded),
        .q_mag_sqr_round_const (q_mag_sqr_round_const),
        .data_in_invSqrt       (data_in_invSqrt),
        .data_out_invSqrt      (data_out_invSqrt),
        .valid_in_invSqrt      (valid_in_invSqrt),
        .ready_in_invSqrt      (ready_in_invSqrt),
        .valid_out_invSqrt     (valid_out_invSqrt),
        .ready_out_invSqrt     (ready_out_invSqrt),
        .debug_state           (debug_state)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    int     exp_comp [4];
    longint exp_mag;
    longint exp_minv;
    int     tol = 2;
    bit     model_valid = 1'b0;
    logic   done_d = 1'b0;

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int comp_of(input logic [4*W-1:0] v, input int i);
        logic signed [W-1:0] c;
        c = v[i*W +: W];
        return int'(c);
    endfunction

    // Ideal result: each component divided by the true Euclidean norm, in Q2.14
    function automatic void model_set(input logic [4*W-1:0] q);
        longint s;
        real    r;
        real    e;
        int     v;
        s = 0;
        for (int i = 0; i < 4; i++)
            s += longint'(comp_of(q, i)) * longint'(comp_of(q, i));
        exp_mag  = s;
        exp_minv = (s + 2) >> 2;
        r = $sqrt(real'(s));
        for (int i = 0; i < 4; i++) begin
            if (s == 0) begin
                v = 0;
            end else begin
                e = real'(comp_of(q, i)) * 16384.0 / r;
                v = int'($floor(e + 0.5));
                if (v > 32767) v = 32767;
                if (v < -32768) v = -32768;
            end
            exp_comp[i] = v;
        end
    endfunction

    // Compare process: result against the model every cycle done is high
    always @(negedge clk) begin
        logic [127:0] iy;
        logic [127:0] im;
        logic [127:0] one;
        bit           ok;
        if (rst_n && model_valid && done) begin
            for (int i = 0; i < 4; i++) begin
                int a;
                a = comp_of(data_out, i);
                chk($sformatf("data_out_c%0d", i), (a - exp_comp[i] <= tol) && (exp_comp[i] - a <= tol),
                    a, exp_comp[i]);
            end
            if (!done_d) begin
                chk("q_mag_sqr", longint'(q_mag_sqr) == exp_mag, longint'(q_mag_sqr), exp_mag);
                chk("invsqrt_operand", longint'(data_in_invSqrt) == exp_minv,
                    longint'(data_in_invSqrt), exp_minv);
                iy  = 128'(data_out_invSqrt);
                im  = 128'(data_in_invSqrt);
                one = 128'd1 << 78;
                if (im == 0)
                    ok = (data_out_invSqrt == 32'hFFFF_FFFF);
                else
                    ok = (iy * iy * im <= one) &&
                         ((data_out_invSqrt == 32'hFFFF_FFFF) || ((iy + 1) * (iy + 1) * im > one));
                chk("invsqrt_floor", ok, longint'(data_out_invSqrt), longint'(data_in_invSqrt));
            end
        end
        done_d = done;
    end

    // One complete request; pulse=1 drops start right after it is sampled
    task automatic run(input logic [4*W-1:0] q, input bit pulse, output int lat);
        model_set(q);
        model_valid = 1'b1;
        @(negedge clk);
        data_in = q;
        start   = 1'b1;
        @(posedge clk);
        #1;
        if (pulse) start = 1'b0;
        data_in = '0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        chk("latency", lat == 36, lat, 36);
        if (!pulse) begin
            repeat (3) @(negedge clk);
            chk("done_held", done == 1'b1, done, 1);
            start = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("back_to_idle_state", debug_state == 3'd0, debug_state, 0);
        chk("back_to_idle_done", done == 1'b0, done, 0);
    endtask

    int lat;
    real mag;
    int a_w, a_x, a_y, a_z;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_data_out", data_out == '0, longint'(data_out), 0);
            chk("rst_done", done == 1'b0, done, 0);
            chk("rst_state", debug_state == 3'd0, debug_state, 0);
        end
        chk("rst_ready_in", ready_in_invSqrt == 1'b1, ready_in_invSqrt, 1);
        chk("rst_valid_out", valid_out_invSqrt == 1'b0, valid_out_invSqrt, 0);

        run(64'h0000_FE10_FF98_0000, 1'b0, lat);
        chk("t2_mag_literal", q_mag_sqr == 35'd256832, longint'(q_mag_sqr), 256832);
        a_x = comp_of(data_out, 2);
        a_y = comp_of(data_out, 1);
        chk("t2_x_literal", (a_x >= -16037) && (a_x <= -16033), a_x, -16035);
        chk("t2_y_literal", (a_y >= -3364) && (a_y <= -3360), a_y, -3362);

        run(64'h0, 1'b0, lat);
        chk("zero_literal", data_out == '0, longint'(data_out), 0);

        tol = 1;
        run(64'h4000_0000_0000_0000, 1'b1, lat);
        chk("unit_w_literal", comp_of(data_out, 3) == 16384, comp_of(data_out, 3), 16384);
        chk("unit_inv_literal", data_out_invSqrt == 32'h0400_0000, longint'(data_out_invSqrt), 32'h0400_0000);

        run(64'h2000_2000_2000_2000, 1'b0, lat);
        chk("half_literal", data_out == 64'h2000_2000_2000_2000, longint'(data_out), 64'h2000_2000_2000_2000);

        tol = 2;
        run(64'h4000_FFEE_000A_FFEF, 1'b0, lat);
        a_w = comp_of(data_out, 3);
        a_x = comp_of(data_out, 2);
        a_y = comp_of(data_out, 1);
        a_z = comp_of(data_out, 0);
        mag = $sqrt(real'(a_w) * a_w + real'(a_x) * a_x + real'(a_y) * a_y + real'(a_z) * a_z);
        chk("t5_magnitude", (mag >= 16382.0) && (mag <= 16386.0), longint'(mag), 16384);
        chk("t5_signs", (a_w > 0) && (a_x < 0) && (a_y > 0) && (a_z < 0), a_x, -1);

        model_valid = 1'b0;
        @(negedge clk);
        data_in = 64'h0000_FE10_FF98_0000;
        start   = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        chk("abort_in_inv_wait", debug_state == 3'd3, debug_state, 3);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("abort_data_out", data_out == '0, longint'(data_out), 0);
        chk("abort_state", debug_state == 3'd0, debug_state, 0);
        chk("abort_done", done == 1'b0, done, 0);
        chk("abort_valid_out", valid_out_invSqrt == 1'b0, valid_out_invSqrt, 0);
        chk("abort_ready_in", ready_in_invSqrt == 1'b1, ready_in_invSqrt, 1);
        chk("abort_inv_result", data_out_invSqrt == '0, longint'(data_out_invSqrt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(64'h0000_FE10_FF98_0000, 1'b0, lat);
        chk("post_abort_x", (comp_of(data_out, 2) >= -16037) && (comp_of(data_out, 2) <= -16033),
            comp_of(data_out, 2), -16035);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
